// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] S_FETCH    = 4'd1;
  localparam logic [STATE_W-1:0] S_DECODE   = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 4'd3;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 4'd4;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 4'd5;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 4'd6;
  localparam logic [STATE_W-1:0] S_R_EXEC   = 4'd7;
  localparam logic [STATE_W-1:0] S_R_WB     = 4'd8;
  localparam logic [STATE_W-1:0] S_ORI_EXEC = 4'd9;
  localparam logic [STATE_W-1:0] S_ORI_WB   = 4'd10;
  localparam logic [STATE_W-1:0] S_BRANCH   = 4'd11;
  localparam logic [STATE_W-1:0] S_JUMP     = 4'd12;
  localparam logic [STATE_W-1:0] S_TRAP     = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold a memory request open and therefore run the wait timer.
  function automatic logic mem_wait_state(input logic [STATE_W-1:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; flags expiry when the limit is reached while
// the access is still outstanding. MEM_TIMEOUT = 0 disables expiry.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (busy && !ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A same-cycle ready beats the limit.
  assign expired = (MEM_TIMEOUT != 0) && busy && !ready && (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (fetch/decode/execute/mem/writeback) with
// memory wait timeout and sticky traps. Optional bne via MULTICYCLE_CONTROL_BNE_EN.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OP_WIDTH     = 6,
  parameter int unsigned ALU_OP_WIDTH = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    branch_ne,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [1:0]              pc_source,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic                    bus_error
);

  logic [STATE_W-1:0]  state, next_state;
  logic [OP_WIDTH-1:0] op_q;
  logic                set_illegal;
  logic                timer_clear, timer_busy, expired;

  assign timer_busy  = mem_wait_state(state);
  assign timer_clear = mem_wait_state(next_state) && (next_state != state);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .busy    (timer_busy),
    .ready   (mem_ready),
    .expired (expired)
  );

  // State, latched opcode and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      illegal_op <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) op_q <= op;
      if (set_illegal) illegal_op <= 1'b1;
      if (expired) bus_error <= 1'b1;
    end
  end

  // Next state and datapath controls decoded from the current state.
  always_comb begin
    next_state    = state;
    set_illegal   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = '0;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_OP_WIDTH'(ALUOP_ADD);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    next_state = S_DECODE;
        else if (expired) next_state = S_TRAP;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_op    = ALU_OP_WIDTH'(ALUOP_ADD);
        if (op == OP_WIDTH'(OP_RTYPE))                              next_state = S_R_EXEC;
        else if (op == OP_WIDTH'(OP_LW) || op == OP_WIDTH'(OP_SW))  next_state = S_MEM_ADDR;
        else if (op == OP_WIDTH'(OP_BEQ))                           next_state = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        else if (op == OP_WIDTH'(OP_BNE))                           next_state = S_BRANCH;
`endif
        else if (op == OP_WIDTH'(OP_J))                             next_state = S_JUMP;
        else if (op == OP_WIDTH'(OP_ORI))                           next_state = S_ORI_EXEC;
        else begin
          next_state  = S_TRAP;
          set_illegal = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_OP_WIDTH'(ALUOP_ADD);
        next_state = (op_q == OP_WIDTH'(OP_SW)) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)    next_state = S_MEM_WB;
        else if (expired) next_state = S_TRAP;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (expired) begin
          next_state = S_TRAP;
        end
      end
      S_R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_OP_WIDTH'(ALUOP_FUNCT);
        next_state = S_R_WB;
      end
      S_R_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_ORI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_OP_WIDTH'(ALUOP_OR);
        next_state = S_ORI_WB;
      end
      S_ORI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_OP_WIDTH'(ALUOP_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
`ifdef MULTICYCLE_CONTROL_BNE_EN
        branch_ne     = (op_q == OP_WIDTH'(OP_BNE));
`endif
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder: a Moore/Mealy FSM sequencing each MIPS instruction through fetch, decode, execute, memory and writeback.
- Drives the shared-datapath muxes, the IR/PC enables and the unified memory port.
- Memory accesses use a ready handshake with a wait-state timeout.
- Supports R-type, ori, lw, sw, beq and j; raises trap flags for illegal opcodes and bus timeouts.

Parameters:
- OP_WIDTH, 6, opcode width.
- ALU_OP_WIDTH, 2, width of the alu_op code sent to the ALU control.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  OP_WIDTH  opcode field from IR.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- branch_ne  out  1  invert zero condition.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback select: 1 = MDR.
- reg_dst  out  1  destination select: 1 = rd.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- alu_op  out  ALU_OP_WIDTH  00 = add, 01 = sub, 10 = funct, 11 = or.
- pc_source  out  2  PC mux: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal_op  out  1  sticky: undefined opcode decoded.
- bus_error  out  1  sticky: memory timeout.

Behaviour:
- Reset: state = S_IDLE, op_q = 0, wait counter = 0, illegal_op = 0, bus_error = 0. Every output is 0 in S_IDLE.
- S_IDLE -> S_FETCH unconditionally on the first edge after reset release.
- Outputs decode from the state register. Exceptions: ir_write, pc_write and instr_done may also depend on mem_ready, as stated per state.
- Any output not listed for a state is 0.
- S_FETCH: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00. ir_write = pc_write = mem_ready. Stay until mem_ready, then -> S_DECODE.
- S_DECODE: op_q <= op; alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by op:
  - 000000 -> S_R_EXEC
  - 100011 or 101011 -> S_MEM_ADDR
  - 000100 -> S_BRANCH
  - 000010 -> S_JUMP
  - 001101 -> S_ORI_EXEC
  - anything else -> S_TRAP
- S_MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. lw -> S_MEM_RD; sw -> S_MEM_WR.
- S_MEM_RD: mem_read = 1, i_or_d = 1. On mem_ready -> S_MEM_WB.
- S_MEM_WB: mem_to_reg = 1, reg_dst = 0, reg_write = 1, instr_done = 1 -> S_FETCH.
- S_MEM_WR: mem_write = 1, i_or_d = 1. On mem_ready: instr_done = 1 -> S_FETCH.
- S_R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10 -> S_R_WB. S_R_WB: reg_dst = 1, reg_write = 1, instr_done = 1 -> S_FETCH.
- S_ORI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11 -> S_ORI_WB. S_ORI_WB: reg_dst = 0, reg_write = 1, instr_done = 1 -> S_FETCH.
- S_BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01, instr_done = 1 -> S_FETCH.
- S_JUMP: pc_write = 1, pc_source = 10, instr_done = 1 -> S_FETCH.
- Wait counter:
  - Clears on entry to S_FETCH, S_MEM_RD or S_MEM_WR.
  - Increments each cycle spent in one of those states with mem_ready = 0.
  - If MEM_TIMEOUT > 0 and the counter equals MEM_TIMEOUT while mem_ready = 0: bus_error <= 1 and next state = S_TRAP.
  - mem_ready on the same cycle as the limit wins: normal transition, no error.
  - Counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- Illegal opcode in S_DECODE: illegal_op <= 1 and the next state is S_TRAP.
- S_TRAP: absorbing state. All outputs 0 except the sticky flags; left only by reset.
- rst_n asserted mid-access forces S_IDLE immediately. No write strobe may be asserted in the reset cycle.
- States after S_DECODE use op_q, never live op.

Optional Feature:
- Macro MULTICYCLE_CONTROL_BNE_EN.
- Defined: opcode 000101 decodes to S_BRANCH and branch_ne = 1 in that state; the other branch outputs are identical to beq.
- Undefined: branch_ne is constant 0 and 000101 traps as illegal.

Decomposition:
- Package mc_ctrl_pkg holds the state localparams (S_IDLE..S_TRAP, 4-bit encoding), opcode constants (OP_RTYPE, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J), alu_op codes and the alu_src_b / pc_source encodings.
- One sub-module, mc_wait_timer: the wait counter plus timeout compare, with inputs clear, busy, ready and output expired.

Test Plan:
- Reset, then op = 000000, mem_ready tied 1 -> states IDLE, FETCH, DECODE, R_EXEC, R_WB; reg_dst = 1 and reg_write = 1 in cycle 5; instr_done pulses once.
- lw with mem_ready low for 3 cycles in S_MEM_RD -> mem_read and i_or_d held 4 cycles; S_MEM_WB has mem_to_reg = 1; total 8 cycles from FETCH, no bus_error.
- sw with MEM_TIMEOUT = 4 and mem_ready never high -> bus_error = 1 after 4 wait cycles; S_TRAP; mem_write drops; state persists for 20 cycles.
- op = 111111 -> illegal_op = 1 the cycle after DECODE; all strobes 0; rst_n pulse clears the flag and restarts at S_IDLE.
- beq, then j -> pc_write_cond = 1 with pc_source = 01, then pc_write = 1 with pc_source = 10; each takes 3 cycles.
- With MULTICYCLE_CONTROL_BNE_EN: op = 000101 -> branch_ne = 1 in S_BRANCH. Without it: illegal_op = 1.
